// File: rtl/bsg_manycore_host_mmio_responder.sv
// bsg_manycore_host_mmio_responder: host-link endpoint serving load/store/swap
// requests against a local register bank with one in-order response register.
module bsg_manycore_host_mmio_responder #(
   parameter int x_cord_width_p = 7,
   parameter int y_cord_width_p = 7,
   parameter int addr_width_p   = 28,
   parameter int data_width_p   = 32,
   parameter int reg_id_width_p = 5,
   parameter int num_regs_p     = 16
)(
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      req_v_i,
   output logic                      req_ready_o,
   input  logic [1:0]                req_op_i,
   input  logic [addr_width_p-1:0]   req_addr_i,
   input  logic [data_width_p-1:0]   req_data_i,
   input  logic [data_width_p/8-1:0] req_mask_i,
   input  logic [reg_id_width_p-1:0] req_reg_id_i,
   input  logic [x_cord_width_p-1:0] req_src_x_i,
   input  logic [y_cord_width_p-1:0] req_src_y_i,
   output logic                      resp_v_o,
   input  logic                      resp_ready_i,
   output logic [1:0]                resp_type_o,
   output logic [data_width_p-1:0]   resp_data_o,
   output logic [reg_id_width_p-1:0] resp_reg_id_o,
   output logic [x_cord_width_p-1:0] resp_dst_x_o,
   output logic [y_cord_width_p-1:0] resp_dst_y_o,
   output logic [31:0]               served_count_o
);
   localparam int mask_w_lp = data_width_p / 8;
   localparam int idx_w_lp  = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;

   logic [data_width_p-1:0]   regs_q [num_regs_p];
   logic [data_width_p-1:0]   regs_d [num_regs_p];
   logic                      resp_v_q, resp_v_d;
   logic [1:0]                resp_type_q, resp_type_d;
   logic [data_width_p-1:0]   resp_data_q, resp_data_d;
   logic [reg_id_width_p-1:0] resp_reg_id_q, resp_reg_id_d;
   logic [x_cord_width_p-1:0] resp_dst_x_q, resp_dst_x_d;
   logic [y_cord_width_p-1:0] resp_dst_y_q, resp_dst_y_d;
   logic [31:0]               served_count_q, served_count_d;
   logic                      accept, in_range;
   logic [idx_w_lp-1:0]       idx;

   assign req_ready_o = ~resp_v_q | resp_ready_i;
   assign accept      = req_v_i & req_ready_o;
   // full-width compare so high address bits can never alias into the bank
   assign in_range    = req_addr_i < addr_width_p'(num_regs_p);
   assign idx         = req_addr_i[idx_w_lp-1:0];

   always_comb begin
      regs_d         = regs_q;
      resp_v_d       = resp_v_q;
      resp_type_d    = resp_type_q;
      resp_data_d    = resp_data_q;
      resp_reg_id_d  = resp_reg_id_q;
      resp_dst_x_d   = resp_dst_x_q;
      resp_dst_y_d   = resp_dst_y_q;
      served_count_d = served_count_q + 32'(resp_v_q & resp_ready_i);
      if (accept) begin
         resp_v_d      = 1'b1;
         resp_type_d   = (req_op_i == 2'b11 || !in_range) ? 2'b10 : (req_op_i == 2'b01) ? 2'b01 : 2'b00;
         resp_data_d   = (in_range && !req_op_i[0]) ? regs_q[idx] : '0;
         resp_reg_id_d = req_reg_id_i;
         resp_dst_x_d  = req_src_x_i;
         resp_dst_y_d  = req_src_y_i;
         if (in_range && req_op_i == 2'b01)
            for (int b = 0; b < mask_w_lp; b++)
               if (req_mask_i[b]) regs_d[idx][8*b +: 8] = req_data_i[8*b +: 8];
         if (in_range && req_op_i == 2'b10) regs_d[idx] = req_data_i;
      end else if (resp_ready_i) begin
         resp_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < num_regs_p; i++) regs_q[i] <= '0;
         resp_v_q       <= 1'b0;
         resp_type_q    <= '0;
         resp_data_q    <= '0;
         resp_reg_id_q  <= '0;
         resp_dst_x_q   <= '0;
         resp_dst_y_q   <= '0;
         served_count_q <= '0;
      end else begin
         regs_q         <= regs_d;
         resp_v_q       <= resp_v_d;
         resp_type_q    <= resp_type_d;
         resp_data_q    <= resp_data_d;
         resp_reg_id_q  <= resp_reg_id_d;
         resp_dst_x_q   <= resp_dst_x_d;
         resp_dst_y_q   <= resp_dst_y_d;
         served_count_q <= served_count_d;
      end
   end

   assign resp_v_o       = resp_v_q;
   assign resp_type_o    = resp_type_q;
   assign resp_data_o    = resp_data_q;
   assign resp_reg_id_o  = resp_reg_id_q;
   assign resp_dst_x_o   = resp_dst_x_q;
   assign resp_dst_y_o   = resp_dst_y_q;
   assign served_count_o = served_count_q;
endmodule

// File: tb/tb_bsg_manycore_host_mmio_responder.sv
// tb_bsg_manycore_host_mmio_responder: scoreboard bench for the host MMIO responder.
module tb_bsg_manycore_host_mmio_responder;
   logic        clk_i = 0, reset_i = 1;
   logic        req_v_i = 0, req_ready_o;
   logic [1:0]  req_op_i = 0;
   logic [27:0] req_addr_i = 0;
   logic [31:0] req_data_i = 0;
   logic [3:0]  req_mask_i = 0;
   logic [4:0]  req_reg_id_i = 0;
   logic [6:0]  req_src_x_i = 0, req_src_y_i = 0;
   logic        resp_v_o, resp_ready_i = 1;
   logic [1:0]  resp_type_o;
   logic [31:0] resp_data_o;
   logic [4:0]  resp_reg_id_o;
   logic [6:0]  resp_dst_x_o, resp_dst_y_o;
   logic [31:0] served_count_o;

   typedef struct packed {
      logic [1:0] t; logic [31:0] d; logic [4:0] id; logic [6:0] x; logic [6:0] y;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] m_regs [16];
   logic [31:0] exp_served = 0;
   int          checks = 0, failures = 0;

   bsg_manycore_host_mmio_responder dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
      .req_reg_id_i(req_reg_id_i), .req_src_x_i(req_src_x_i), .req_src_y_i(req_src_y_i),
      .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_type_o(resp_type_o),
      .resp_data_o(resp_data_o), .resp_reg_id_o(resp_reg_id_o),
      .resp_dst_x_o(resp_dst_x_o), .resp_dst_y_o(resp_dst_y_o),
      .served_count_o(served_count_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (!reset_i && resp_v_o && resp_ready_i) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL resp_unexpected: got type=%0d data=%h with empty scoreboard", resp_type_o, resp_data_o);
         end else begin
            mon_e = sb.pop_front();
            if ({resp_type_o, resp_data_o, resp_reg_id_o, resp_dst_x_o, resp_dst_y_o} !== mon_e) begin
               failures++;
               $display("FAIL resp_fields: got t=%0d d=%h id=%0d x=%0d y=%0d, required t=%0d d=%h id=%0d x=%0d y=%0d",
                        resp_type_o, resp_data_o, resp_reg_id_o, resp_dst_x_o, resp_dst_y_o,
                        mon_e.t, mon_e.d, mon_e.id, mon_e.x, mon_e.y);
            end
         end
         exp_served++;
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      sb.delete();
      exp_served = 0;
   endtask

   // drives one request (caller sits just after a rising edge) and pushes the model's expectation
   task automatic send(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [4:0] id, input logic [6:0] x, input logic [6:0] y);
      exp_t e;
      bit   ok = 0;
      bit   inr = addr < 28'd16;
      req_v_i = 1; req_op_i = op; req_addr_i = addr; req_data_i = data;
      req_mask_i = mask; req_reg_id_i = id; req_src_x_i = x; req_src_y_i = y;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk_i);
         if (req_ready_o) ok = 1;
         else begin @(posedge clk_i); #1; end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL accept: req_ready_o stayed 0 for 40 cycles (op=%0d addr=%0d), required 1", op, addr);
      end else begin
         e.t  = (op == 2'b11 || !inr) ? 2'b10 : (op == 2'b01) ? 2'b01 : 2'b00;
         e.d  = (inr && (op == 2'b00 || op == 2'b10)) ? m_regs[addr[3:0]] : 32'h0;
         e.id = id; e.x = x; e.y = y;
         sb.push_back(e);
         if (inr && op == 2'b01)
            for (int b = 0; b < 4; b++) if (mask[b]) m_regs[addr[3:0]][8*b +: 8] = data[8*b +: 8];
         if (inr && op == 2'b10) m_regs[addr[3:0]] = data;
      end
      @(posedge clk_i); #1;
   endtask

   task automatic drain();
      int n = 0;
      req_v_i = 0;
      while (sb.size() != 0 && n < 30) begin @(posedge clk_i); n++; end
      if (n > 0) #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d responses outstanding after 30 cycles, required 0", sb.size());
      end
      checks++;
      if (served_count_o !== exp_served) begin
         failures++;
         $display("FAIL served_count: got %0d, required %0d", served_count_o, exp_served);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({resp_v_o, resp_type_o, resp_data_o, resp_reg_id_o, resp_dst_x_o, resp_dst_y_o, served_count_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b d=%h cnt=%0d, required all 0", resp_v_o, resp_data_o, served_count_o);
      end
      @(posedge clk_i); #1;
      reset_i = 0;
      model_clear();
      checks++;
      if (req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b, required 1", req_ready_o);
      end
   endtask

   task automatic test_reset_mid();
      send(2'b01, 28'd5, 32'h12345678, 4'hF, 5'd9, 7'd3, 7'd4);
      drain();
      resp_ready_i = 0;
      send(2'b00, 28'd5, 32'h0, 4'h0, 5'd10, 7'd3, 7'd4);
      req_v_i = 0;
      #2 reset_i = 1;
      #1;
      checks++;
      if ({resp_v_o, resp_type_o, resp_data_o, resp_reg_id_o, resp_dst_x_o, resp_dst_y_o, served_count_o} !== '0) begin
         failures++;
         $display("FAIL reset_mid_outputs: got v=%b d=%h id=%0d cnt=%0d, required all 0",
                  resp_v_o, resp_data_o, resp_reg_id_o, served_count_o);
      end
      model_clear();
      @(posedge clk_i); #1;
      reset_i = 0;
      resp_ready_i = 1;
      checks++;
      if (req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_ready: got %b, required 1", req_ready_o);
      end
      @(negedge clk_i);
      checks++;
      if (resp_v_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_replay: resp_v_o=%b after release, required 0", resp_v_o);
      end
      @(posedge clk_i); #1;
      send(2'b00, 28'd5, 32'h0, 4'h0, 5'd11, 7'd3, 7'd4);
      drain();
   endtask

   task automatic test_store_load();
      send(2'b01, 28'd3, 32'hDEADBEEF, 4'hF, 5'd5, 7'd2, 7'd1);
      send(2'b00, 28'd3, 32'h0, 4'h0, 5'd6, 7'd2, 7'd1);
      drain();
   endtask

   task automatic test_mask_swap();
      send(2'b01, 28'd3, 32'h11223344, 4'h5, 5'd7, 7'd8, 7'd9);
      send(2'b00, 28'd3, 32'h0, 4'h0, 5'd8, 7'd8, 7'd9);
      send(2'b10, 28'd3, 32'hCAFEF00D, 4'h0, 5'd12, 7'd1, 7'd2);
      send(2'b00, 28'd3, 32'h0, 4'h0, 5'd13, 7'd1, 7'd2);
      send(2'b01, 28'd3, 32'hFFFFFFFF, 4'h0, 5'd14, 7'd1, 7'd2);
      send(2'b00, 28'd3, 32'h0, 4'h0, 5'd15, 7'd1, 7'd2);
      send(2'b10, 28'd15, 32'hA5A55A5A, 4'h0, 5'd16, 7'd0, 7'd0);
      send(2'b00, 28'd15, 32'h0, 4'h0, 5'd17, 7'd0, 7'd0);
      drain();
   endtask

   task automatic test_errors();
      send(2'b00, 28'd16, 32'h0, 4'h0, 5'd20, 7'd5, 7'd5);
      send(2'b11, 28'd0, 32'hFFFFFFFF, 4'hF, 5'd21, 7'd5, 7'd5);
      send(2'b01, 28'h8000003, 32'h55555555, 4'hF, 5'd22, 7'd5, 7'd5);
      send(2'b10, 28'h0000013, 32'h77777777, 4'h0, 5'd23, 7'd5, 7'd5);
      send(2'b00, 28'd0, 32'h0, 4'h0, 5'd24, 7'd5, 7'd5);
      send(2'b00, 28'd3, 32'h0, 4'h0, 5'd25, 7'd5, 7'd5);
      drain();
   endtask

   task automatic test_backpressure();
      logic [52:0] snap;
      logic [31:0] base;
      resp_ready_i = 0;
      send(2'b00, 28'd3, 32'h0, 4'h0, 5'd1, 7'd10, 7'd11);
      snap = {resp_type_o, resp_data_o, resp_reg_id_o, resp_dst_x_o, resp_dst_y_o};
      req_v_i = 1; req_op_i = 2'b01; req_addr_i = 28'd7; req_data_i = 32'h0BADF00D; req_mask_i = 4'hF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         checks++;
         if (req_ready_o !== 1'b0 || resp_v_o !== 1'b1 ||
             {resp_type_o, resp_data_o, resp_reg_id_o, resp_dst_x_o, resp_dst_y_o} !== snap) begin
            failures++;
            $display("FAIL backpressure_hold cycle %0d: ready=%b v=%b fields=%h, required ready=0 v=1 fields=%h",
                     i, req_ready_o, resp_v_o,
                     {resp_type_o, resp_data_o, resp_reg_id_o, resp_dst_x_o, resp_dst_y_o}, snap);
         end
         @(posedge clk_i); #1;
      end
      resp_ready_i = 1;
      base = served_count_o;
      send(2'b01, 28'd7, 32'h0BADF00D, 4'hF, 5'd2, 7'd10, 7'd11);
      send(2'b00, 28'd7, 32'h0, 4'h0, 5'd3, 7'd10, 7'd11);
      req_v_i = 0;
      @(negedge clk_i);
      checks++;
      if (resp_v_o !== 1'b1 || served_count_o !== base + 32'd2) begin
         failures++;
         $display("FAIL backpressure_consecutive: v=%b count=%0d, required v=1 count=%0d", resp_v_o, served_count_o, base + 32'd2);
      end
      @(posedge clk_i); #1;
      drain();
   endtask

   task automatic test_counter_wrap();
      force dut.served_count_q = 32'hFFFFFFFF;
      #1 release dut.served_count_q;
      exp_served = 32'hFFFFFFFF;
      checks++;
      if (served_count_o !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL wrap_preload: got %h, required ffffffff", served_count_o);
      end
      @(posedge clk_i); #1;
      send(2'b00, 28'd0, 32'h0, 4'h0, 5'd30, 7'd1, 7'd1);
      drain();
      checks++;
      if (served_count_o !== 32'h0) begin
         failures++;
         $display("FAIL wrap: got %h, required 0", served_count_o);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_store_load();
      test_mask_swap();
      test_errors();
      test_backpressure();
      test_counter_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
